// File: rtl/demux2_pkg.sv
// Shared constants for the two-channel serial-to-parallel deserializer.
// Channel select encodings and the default word width live here.
package demux2_pkg;
    localparam int   DEF_WIDTH = 4;
    localparam int   CNT_W     = $clog2(DEF_WIDTH + 1);
    localparam logic CH1       = 1'b0;
    localparam logic CH2       = 1'b1;
endpackage

// File: rtl/demux_chan_deser.sv
// One deserializer lane: LSB-first shift register, bit counter and an output
// holding register with a valid/ready handshake.
module demux_chan_deser
    import demux2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_take,
    input  logic                       i_bit,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_word,
    output logic                       o_valid,
    output logic [$clog2(WIDTH+1)-1:0] o_cnt,
    output logic                       o_stall
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_word;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic [WIDTH-1:0] w_shift;
    logic             w_last;
    logic             w_done;

    assign w_last = (r_cnt == CW'(WIDTH - 1));
    assign w_done = i_take & w_last;

    // Compare-based write avoids indexing with a counter wider than the index.
    always_comb begin
        w_shift = r_shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_cnt == CW'(i)) w_shift[i] = i_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_word  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_take) begin
                if (w_last) begin
                    r_word <= w_shift;
                    r_cnt  <= '0;
                end else begin
                    r_shift <= w_shift;
                    r_cnt   <= r_cnt + CW'(1);
                end
            end
            // A completing word wins over a consume on the same edge: no bubble.
            if (w_done)
                r_valid <= 1'b1;
            else if (r_valid && i_ready)
                r_valid <= 1'b0;
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;
    assign o_cnt   = r_cnt;
    assign o_stall = w_last & r_valid & ~i_ready;
endmodule

// File: rtl/demux2_deserializer.sv
// Two-channel deserializer: S steers each accepted serial bit to channel 1 or 2.
// Top holds only select decode and the in_ready mux.
module demux2_deserializer
    import demux2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       S,
    input  logic                       A,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           Y1_word,
    output logic                       Y1_valid,
    input  logic                       Y1_ready,
    output logic [WIDTH-1:0]           Y2_word,
    output logic                       Y2_valid,
    input  logic                       Y2_ready,
    output logic [$clog2(WIDTH+1)-1:0] Y1_cnt,
    output logic [$clog2(WIDTH+1)-1:0] Y2_cnt
);
    logic w_sel;
    logic w_acc;
    logic w_take1;
    logic w_take2;
    logic w_stall1;
    logic w_stall2;

    // Gating S with in_valid keeps an undriven select out of in_ready.
    assign w_sel    = in_valid & S;
    assign in_ready = (w_sel == CH2) ? ~w_stall2 : ~w_stall1;
    assign w_acc    = in_valid & in_ready;
    assign w_take1  = w_acc & (w_sel == CH1);
    assign w_take2  = w_acc & (w_sel == CH2);

    demux_chan_deser #(.WIDTH(WIDTH)) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .i_take  (w_take1),
        .i_bit   (A),
        .i_ready (Y1_ready),
        .o_word  (Y1_word),
        .o_valid (Y1_valid),
        .o_cnt   (Y1_cnt),
        .o_stall (w_stall1)
    );

    demux_chan_deser #(.WIDTH(WIDTH)) u_ch2 (
        .clk     (clk),
        .rst     (rst),
        .i_take  (w_take2),
        .i_bit   (A),
        .i_ready (Y2_ready),
        .o_word  (Y2_word),
        .o_valid (Y2_valid),
        .o_cnt   (Y2_cnt),
        .o_stall (w_stall2)
    );
endmodule

// File: tb/tb_demux2_deserializer.sv
// Directed bench for demux2_deserializer (WIDTH=4): a bit-level model pushes
// expected words per channel, and a negedge monitor pops them on each consume.
module tb_demux2_deserializer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         S, A, in_valid, in_ready;
    logic [W-1:0] Y1_word, Y2_word;
    logic         Y1_valid, Y2_valid, Y1_ready, Y2_ready;
    logic [2:0]   Y1_cnt, Y2_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    logic [W-1:0] m_shift[2];
    int           m_cnt[2];

    always #5 clk = ~clk;

    demux2_deserializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .S(S), .A(A), .in_valid(in_valid), .in_ready(in_ready),
        .Y1_word(Y1_word), .Y1_valid(Y1_valid), .Y1_ready(Y1_ready),
        .Y2_word(Y2_word), .Y2_valid(Y2_valid), .Y2_ready(Y2_ready),
        .Y1_cnt(Y1_cnt), .Y2_cnt(Y2_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one bit, wait (bounded) for in_ready, then update the model on the accepting edge.
    task automatic send_bit(input logic s, input logic a);
        bit got = 0;
        in_valid = 1'b1; S = s; A = a;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1;
                break;
            end
            step();
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $error("FAIL send_timeout: observed in_ready=%0b expected 1", in_ready);
        end else begin
            m_shift[s][m_cnt[s]] = a;
            m_cnt[s]++;
            if (m_cnt[s] == W) begin
                if (s) q2.push_back(m_shift[s]);
                else   q1.push_back(m_shift[s]);
                m_cnt[s] = 0;
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    // Scoreboard: a word is consumed at the next edge whenever valid & ready.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (Y1_valid === 1'b1 && Y1_ready === 1'b1) begin
                if (q1.size() == 0) chk("y1_sb_empty", {31'd0, Y1_valid}, 32'd0);
                else                chk("y1_sb", {28'd0, Y1_word}, {28'd0, q1.pop_front()});
            end
            if (Y2_valid === 1'b1 && Y2_ready === 1'b1) begin
                if (q2.size() == 0) chk("y2_sb_empty", {31'd0, Y2_valid}, 32'd0);
                else                chk("y2_sb", {28'd0, Y2_word}, {28'd0, q2.pop_front()});
            end
        end
    end

    initial begin
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_shift[0] = '0; m_shift[1] = '0;
        rst = 1'b1; in_valid = 1'b0; S = 1'b0; A = 1'b0;
        Y1_ready = 1'b1; Y2_ready = 1'b1;
        step(); step();
        @(negedge clk);
        chk("rst_y1_valid", {31'd0, Y1_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        step();

        // 1: reset mid-word
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        @(negedge clk);
        chk("t1_cnt_mid", {29'd0, Y1_cnt}, 32'd2);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        m_cnt[0] = 0;
        @(negedge clk);
        chk("t1_cnt", {29'd0, Y1_cnt}, 32'd0);
        chk("t1_y1_valid", {31'd0, Y1_valid}, 32'd0);
        chk("t1_y2_valid", {31'd0, Y2_valid}, 32'd0);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // 2: single channel-1 word
        send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b1);
        @(negedge clk);
        chk("t2_valid", {31'd0, Y1_valid}, 32'd1);
        chk("t2_word", {28'd0, Y1_word}, 32'hD);
        chk("t2_y2_cnt", {29'd0, Y2_cnt}, 32'd0);
        step();

        // 3: interleaved channels, both held
        Y1_ready = 1'b0; Y2_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(i[0], ~i[0]);
        @(negedge clk);
        chk("t3_y1_valid", {31'd0, Y1_valid}, 32'd1);
        chk("t3_y2_valid", {31'd0, Y2_valid}, 32'd1);
        chk("t3_y1_word", {28'd0, Y1_word}, 32'hF);
        chk("t3_y2_word", {28'd0, Y2_word}, 32'h0);
        step();
        Y1_ready = 1'b1; Y2_ready = 1'b1;
        step(); step();

        // 4: backpressure on channel 2
        Y2_ready = 1'b0;
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
        in_valid = 1'b1; S = 1'b1; A = 1'b1;
        @(negedge clk);
        chk("t4_stall", {31'd0, in_ready}, 32'd0);
        chk("t4_cnt", {29'd0, Y2_cnt}, 32'd3);
        step();
        @(negedge clk);
        chk("t4_stall_hold", {31'd0, in_ready}, 32'd0);
        chk("t4_word_hold", {28'd0, Y2_word}, 32'hA);
        step();
        Y2_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        @(negedge clk);
        chk("t4_new_valid", {31'd0, Y2_valid}, 32'd1);
        chk("t4_new_word", {28'd0, Y2_word}, 32'hB);
        step();

        // 5: consume and complete on the same edge
        Y1_ready = 1'b0;
        send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
        @(negedge clk);
        chk("t5_old_word", {28'd0, Y1_word}, 32'h3);
        step();
        Y1_ready = 1'b1;
        send_bit(1'b0, 1'b1);
        @(negedge clk);
        chk("t5_valid", {31'd0, Y1_valid}, 32'd1);
        chk("t5_word", {28'd0, Y1_word}, 32'hA);
        step();

        // 6: idle input with toggling and unknown S/A
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            S = (i % 3 == 0) ? 1'bx : i[0];
            A = (i % 4 == 1) ? 1'bx : i[1];
            step();
        end
        @(negedge clk);
        chk("t6_y1_cnt", {29'd0, Y1_cnt}, 32'd1);
        chk("t6_y2_cnt", {29'd0, Y2_cnt}, 32'd2);
        chk("t6_y1_word", {28'd0, Y1_word}, 32'hA);
        chk("t6_y2_word", {28'd0, Y2_word}, 32'hB);
        chk("t6_y1_valid", {31'd0, Y1_valid}, 32'd0);
        chk("t6_y2_valid", {31'd0, Y2_valid}, 32'd0);
        S = 1'b0; A = 1'b0;
        step();

        chk("sb_q1_drained", q1.size(), 32'd0);
        chk("sb_q2_drained", q2.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
